// File: rtl/adder_psum_scheduler_if.sv
// PE psum request bus and packet bus between the psum scheduler and its neighbours.
// The master side is the scheduler; the slave side is the PEs plus the adder encoder.
interface adder_psum_scheduler_if #(
  parameter int N_PE     = 3,
  parameter int PSUM_W   = 8,
  parameter int PACKET_W = PSUM_W + 1
);
  logic [N_PE-1:0]        pe_valid;
  logic [N_PE*PSUM_W-1:0] pe_psum;
  logic [N_PE-1:0]        pe_ready;
  logic                   pkt_valid;
  logic [PACKET_W-1:0]    pkt_data;
  logic                   pkt_ready;

  modport master (
    input  pe_valid, pe_psum, pkt_ready,
    output pe_ready, pkt_valid, pkt_data
  );

  modport slave (
    output pe_valid, pe_psum, pkt_ready,
    input  pe_ready, pkt_valid, pkt_data
  );
endinterface

// File: rtl/adder_psum_scheduler.sv
// Shares one adder between N_PE psum requesters round-robin, accumulates one psum per PE
// per neuron, thresholds the sum and emits one {spike, psum} packet per neuron.
//
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | granting PEs until every PE has delivered its psum for this neuron
//   EVAL    | threshold and saturate the sum, register the packet
//   SEND    | hold the packet until the encoder accepts it
module adder_psum_scheduler #(
  parameter int N_PE       = 3,
  parameter int PSUM_W     = 8,
  parameter int PACKET_W   = PSUM_W + 1,
  parameter int ACC_W      = PSUM_W + $clog2(N_PE),
  parameter int THRESH     = 64,
  parameter int NUM_NEURON = 25,
  parameter int IDX_W      = $clog2(NUM_NEURON)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  adder_psum_scheduler_if.master bus,
  output logic [IDX_W-1:0]      neuron_idx,
  output logic                  busy,
  output logic                  done
);
  localparam int PTR_W = (N_PE > 1) ? $clog2(N_PE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_EVAL,
    S_SEND
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [N_PE-1:0]     mask;
  logic [ACC_W-1:0]    acc;
  logic                pkt_valid_q;
  logic [PACKET_W-1:0] pkt_data_q;

  logic [N_PE-1:0]     eligible;
  logic [N_PE-1:0]     grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                found;
  logic [PTR_W-1:0]    rr_next;
  logic [PSUM_W-1:0]   psum_sel;
  logic                spike;
  logic [ACC_W-1:0]    res;
  logic [PSUM_W-1:0]   field;

  // Search downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    int j;
    eligible  = bus.pe_valid & ~mask;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (state == S_COLLECT) begin
      for (int k = N_PE - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= N_PE) j = j - N_PE;
        if (eligible[j]) begin
          grant_idx = PTR_W'(j);
          found     = 1'b1;
        end
      end
    end
    grant = found ? (N_PE'(1) << grant_idx) : '0;
  end

  assign rr_next  = (grant_idx == PTR_W'(N_PE - 1)) ? '0 : grant_idx + 1'b1;
  assign psum_sel = bus.pe_psum[grant_idx*PSUM_W +: PSUM_W];

  assign spike = (acc >= ACC_W'(THRESH));
  assign res   = spike ? (acc - ACC_W'(THRESH)) : acc;
  assign field = (res > ACC_W'((1 << PSUM_W) - 1)) ? {PSUM_W{1'b1}} : res[PSUM_W-1:0];

  assign bus.pe_ready  = grant;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      mask        <= '0;
      acc         <= '0;
      neuron_idx  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_COLLECT;
            neuron_idx <= '0;
            acc        <= '0;
            mask       <= '0;
            busy       <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (found) begin
            acc    <= acc + ACC_W'(psum_sel);
            mask   <= mask | grant;
            rr_ptr <= rr_next;
            if (&(mask | grant)) state <= S_EVAL;
          end
        end
        S_EVAL: begin
          pkt_data_q  <= {spike, field};
          pkt_valid_q <= 1'b1;
          state       <= S_SEND;
        end
        S_SEND: begin
          if (pkt_valid_q && bus.pkt_ready) begin
            pkt_valid_q <= 1'b0;
            if (neuron_idx == IDX_W'(NUM_NEURON - 1)) begin
              state      <= S_IDLE;
              done       <= 1'b1;
              busy       <= 1'b0;
              neuron_idx <= '0;
            end else begin
              neuron_idx <= neuron_idx + 1'b1;
              acc        <= '0;
              mask       <= '0;
              state      <= S_COLLECT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_psum_scheduler.sv
// Randomized bench for adder_psum_scheduler against a per-neuron sum/threshold reference model.
module tb_adder_psum_scheduler;
  localparam int N_PE       = 3;
  localparam int PSUM_W     = 8;
  localparam int PACKET_W   = 9;
  localparam int THRESH     = 64;
  localparam int NUM_NEURON = 25;
  localparam int IDX_W      = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] neuron_idx;

  adder_psum_scheduler_if #(.N_PE(N_PE), .PSUM_W(PSUM_W), .PACKET_W(PACKET_W)) bus ();

  adder_psum_scheduler #(
    .N_PE(N_PE), .PSUM_W(PSUM_W), .PACKET_W(PACKET_W), .ACC_W(10),
    .THRESH(THRESH), .NUM_NEURON(NUM_NEURON), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .neuron_idx(neuron_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [PSUM_W-1:0]   psums [NUM_NEURON][N_PE];
  int                  pe_n [N_PE];
  bit                  in_ts, eval_m, pend_m, done_m, hold_prev;
  int                  rr_m, got_m, nidx_m, hold_cnt;
  bit [N_PE-1:0]       taken;
  logic [PACKET_W-1:0] prev_data;
  int                  valid_pct, ready_pct;
  bit                  directed, rst_req;
  logic [PACKET_W-1:0] dir_exp [3] = '{9'h03C, 9'h11A, 9'h1FF};

  function automatic logic [PACKET_W-1:0] ref_pkt(input int n);
    int s;
    s = 0;
    for (int i = 0; i < N_PE; i++) s += int'(psums[n][i]);
    if (s >= THRESH) begin
      s = s - THRESH;
      return {1'b1, (s > (1 << PSUM_W) - 1) ? {PSUM_W{1'b1}} : PSUM_W'(s)};
    end
    return {1'b0, PSUM_W'(s)};
  endfunction

  task automatic drive_inputs(input bit st);
    start = st;
    for (int i = 0; i < N_PE; i++) begin
      if (pe_n[i] < NUM_NEURON && $urandom_range(99) < valid_pct) begin
        bus.pe_valid[i] = 1'b1;
        bus.pe_psum[i*PSUM_W +: PSUM_W] = psums[pe_n[i]][i];
      end else begin
        bus.pe_valid[i] = 1'b0;
        bus.pe_psum[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
      end
    end
    if (hold_cnt > 0) begin
      bus.pkt_ready = 1'b0;
      hold_cnt--;
    end else begin
      bus.pkt_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic do_reset_check();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_pkt_valid",  32'(bus.pkt_valid), 32'(0));
    check_val("rst_pkt_data",   32'(bus.pkt_data),  32'(0));
    check_val("rst_pe_ready",   32'(bus.pe_ready),  32'(0));
    check_val("rst_busy",       32'(busy),          32'(0));
    check_val("rst_done",       32'(done),          32'(0));
    check_val("rst_neuron_idx", 32'(neuron_idx),    32'(0));
    in_ts = 0; eval_m = 0; pend_m = 0; done_m = 0; hold_prev = 0;
    rr_m = 0; got_m = 0; nidx_m = 0; taken = '0; hold_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive after the edge, check at the falling edge, advance the model.
  task automatic cycle(input bit st);
    logic [N_PE-1:0] pv, exp_rdy;
    int g;
    bit acc_pkt;
    drive_inputs(st);
    @(negedge clk);
    pv = bus.pe_valid;
    g = -1;
    if (in_ts && got_m < N_PE) begin
      for (int k = 0; k < N_PE; k++) begin
        int j;
        j = (rr_m + k) % N_PE;
        if (g < 0 && pv[j] && !taken[j]) g = j;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    check_val("pe_ready",   32'(bus.pe_ready),  32'(exp_rdy));
    check_val("pkt_valid",  32'(bus.pkt_valid), 32'(pend_m));
    if (pend_m) check_val("pkt_data", 32'(bus.pkt_data), 32'(ref_pkt(nidx_m)));
    if (pend_m && directed && nidx_m < 3)
      check_val("pkt_directed", 32'(bus.pkt_data), 32'(dir_exp[nidx_m]));
    if (hold_prev) check_val("pkt_stable", 32'(bus.pkt_data), 32'(prev_data));
    check_val("busy",       32'(busy),       32'(in_ts));
    check_val("done",       32'(done),       32'(done_m));
    check_val("neuron_idx", 32'(neuron_idx), 32'(nidx_m));

    if (rst_req && pend_m && nidx_m == 5) begin
      rst_req = 0;
      do_reset_check();
      return;
    end

    acc_pkt   = pend_m && bus.pkt_ready;
    hold_prev = pend_m && !bus.pkt_ready;
    prev_data = bus.pkt_data;
    done_m    = 0;
    if (!in_ts) begin
      if (st) begin
        in_ts = 1; nidx_m = 0; got_m = 0; taken = '0;
      end
    end else if (g >= 0) begin
      taken[g] = 1'b1;
      got_m++;
      pe_n[g]++;
      rr_m = (g + 1) % N_PE;
      if (got_m == N_PE) eval_m = 1;
    end else if (eval_m) begin
      eval_m = 0;
      pend_m = 1;
      if (directed && nidx_m == 3) hold_cnt = 5;
    end else if (acc_pkt) begin
      pend_m = 0;
      if (nidx_m == NUM_NEURON - 1) begin
        in_ts = 0; done_m = 1; nidx_m = 0;
      end else begin
        nidx_m++; got_m = 0; taken = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_ts(input int vp, input int rp, input bit dir, input bit do_rst);
    int cyc;
    int hi;
    valid_pct = vp; ready_pct = rp; directed = dir; rst_req = do_rst;
    for (int n = 0; n < NUM_NEURON; n++) begin
      case ($urandom_range(2))
        0:       hi = 20;
        1:       hi = 50;
        default: hi = 255;
      endcase
      for (int i = 0; i < N_PE; i++) psums[n][i] = PSUM_W'($urandom_range(hi));
    end
    if (dir) begin
      psums[0][0] = 8'd10;  psums[0][1] = 8'd20;  psums[0][2] = 8'd30;
      psums[1][0] = 8'd40;  psums[1][1] = 8'd30;  psums[1][2] = 8'd20;
      psums[2][0] = 8'd255; psums[2][1] = 8'd255; psums[2][2] = 8'd255;
    end
    for (int i = 0; i < N_PE; i++) pe_n[i] = 0;
    cycle(1'b1);
    cyc = 0;
    while (in_ts && cyc < 3000) begin
      cycle($urandom_range(99) < 3);
      cyc++;
    end
    check_val("ts_in_budget", 32'(cyc < 3000), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.pe_valid  = '0;
    bus.pe_psum   = '0;
    bus.pkt_ready = 1'b0;
    in_ts = 0; eval_m = 0; pend_m = 0; done_m = 0; hold_prev = 0;
    rr_m = 0; got_m = 0; nidx_m = 0; hold_cnt = 0; taken = '0;
    prev_data = '0; valid_pct = 50; ready_pct = 50; directed = 0; rst_req = 0;
    for (int i = 0; i < N_PE; i++) pe_n[i] = NUM_NEURON;
    #1;
    check_val("init_busy",      32'(busy),          32'(0));
    check_val("init_pkt_valid", 32'(bus.pkt_valid), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0);
    run_ts(100, 100, 1'b1, 1'b0);
    repeat (2) cycle(1'b0);
    run_ts(60, 50, 1'b0, 1'b0);
    run_ts(70, 60, 1'b0, 1'b1);
    repeat (3) cycle(1'b0);
    run_ts(40, 70, 1'b0, 1'b0);
    run_ts(25, 90, 1'b0, 1'b0);
    repeat (2) cycle(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
